// File: rtl/four_digit_led_pkg.sv
// Shared constants, message ROM and glyph decode for the LED driver.
// Optional dp start-of-message mark: FOUR_DIGIT_LED_DP_MARK_EN.
package four_digit_led_pkg;

  localparam int MSG_LEN = 16;

  localparam logic [4*MSG_LEN-1:0] MSG_ROM =
    64'hFEDC_BA98_7654_3210;

  typedef enum logic [1:0] {
    DIG3 = 2'd0,
    DIG2 = 2'd1,
    DIG1 = 2'd2,
    DIG0 = 2'd3
  } digit_t;

  function automatic logic [3:0] msg_at(
    input logic [3:0] idx
  );
    return MSG_ROM[{idx, 2'b00} +: 4];
  endfunction

  // abcdefg, active-low
  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] h
  );
    logic [6:0] s;
    s = 7'b111_1111;
    unique case (h)
      4'h0: s = 7'b000_0001;
      4'h1: s = 7'b100_1111;
      4'h2: s = 7'b001_0010;
      4'h3: s = 7'b000_0110;
      4'h4: s = 7'b100_1100;
      4'h5: s = 7'b010_0100;
      4'h6: s = 7'b010_0000;
      4'h7: s = 7'b000_1111;
      4'h8: s = 7'b000_0000;
      4'h9: s = 7'b000_0100;
      4'hA: s = 7'b000_1000;
      4'hB: s = 7'b110_0000;
      4'hC: s = 7'b011_0001;
      4'hD: s = 7'b100_0010;
      4'hE: s = 7'b011_0000;
      4'hF: s = 7'b011_1000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-count filter for a bouncy button.
// Emits the filtered level and a one-cycle pulse on each accepted press.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // bring the raw pin into the clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
    end
  end

  // flip the level only after a long enough disagreement
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level       <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == LAST) begin
          level       <= sync2;
          cnt         <= '0;
          press_pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/four_digit_led_driver.sv
// Four-digit scrolling hex display with debounced advance button.
// Define FOUR_DIGIT_LED_DP_MARK_EN to light dp on the message start.
module four_digit_led_driver #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DIGIT_CYCLES    = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic an3,
  output logic an2,
  output logic an1,
  output logic an0,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic e,
  output logic f,
  output logic g,
  output logic dp
);

  import four_digit_led_pkg::*;

  localparam int SW = $clog2(DIGIT_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST =
    SW'(DIGIT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_ON = SW'(2);

  logic          level;
  logic          press_pulse;
  logic [3:0]    ptr;
  logic [SW-1:0] slot;
  digit_t        dig;
  logic [3:0]    char_idx;
  logic [3:0]    an_sel;
  logic [3:0]    an_q;
  logic [6:0]    seg_q;
  logic          load;
  logic          active;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .clk        (clk),
    .reset      (reset),
    .button     (button),
    .level      (level),
    .press_pulse(press_pulse)
  );

  assign load     = (slot == '0);
  assign active   = (slot >= SLOT_ON);
  assign char_idx = ptr + {2'b00, dig};

  // window pointer, one step per accepted press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (press_pulse && level) begin
      ptr <= ptr + 4'd1;
    end
  end

  // slot counter and digit rotation an3..an0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
      dig  <= DIG3;
    end else if (slot == SLOT_LAST) begin
      slot <= '0;
      dig  <= digit_t'(dig + 2'd1);
    end else begin
      slot <= slot + 1'b1;
    end
  end

  // anode pattern for the selected digit
  always_comb begin
    an_sel = 4'b1111;
    unique case (dig)
      DIG3: an_sel = 4'b0111;
      DIG2: an_sel = 4'b1011;
      DIG1: an_sel = 4'b1101;
      DIG0: an_sel = 4'b1110;
    endcase
  end

  // registered anodes and glyph latched at slot start
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b111_1111;
    end else begin
      an_q <= active ? an_sel : 4'b1111;
      if (load) begin
        seg_q <= hex_to_seg(msg_at(char_idx));
      end
    end
  end

`ifdef FOUR_DIGIT_LED_DP_MARK_EN
  logic mark_q;
  logic dp_q;

  // dp marks the digit holding message index 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mark_q <= 1'b0;
      dp_q   <= 1'b1;
    end else begin
      if (load) begin
        mark_q <= (char_idx == 4'd0);
      end
      dp_q <= ~(active & mark_q);
    end
  end

  assign dp = dp_q;
`else
  assign dp = 1'b1;
`endif

  assign {an3, an2, an1, an0} = an_q;
  assign {a, b, c, d, e, f, g} = seg_q;

endmodule

// File: tb/tb_four_digit_led_driver.sv
// Randomized self-checking bench for four_digit_led_driver.
// Model: press count mod 16 plus an ideal frame timeline.
module tb_four_digit_led_driver;

  localparam int DEB = 16;
  localparam int DC  = 16;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic button = 1'b0;
  logic an3, an2, an1, an0;
  logic a, b, c, d, e, f, g, dp;

  int checks = 0;
  int failures = 0;
  int ptr_m = 0;

  // lit segments abcdefg, active-high
  localparam logic [6:0] LIT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79,
    7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F,
    7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  always #5 clk = ~clk;

  four_digit_led_driver #(
    .DEBOUNCE_CYCLES(DEB),
    .DIGIT_CYCLES   (DC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .button(button),
    .an3   (an3),
    .an2   (an2),
    .an1   (an1),
    .an0   (an0),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .e     (e),
    .f     (f),
    .g     (g),
    .dp    (dp)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    return ~LIT[v % 16];
  endfunction

  task automatic bounce(input logic fin);
    int t;
    t = 0;
    while (t < 100) begin
      int dt;
      dt = $urandom_range(5, 15);
      button = ~button;
      #dt;
      t += dt;
    end
    button = fin;
  endtask

  task automatic press(input bit bouncy, input int hold);
    @(negedge clk);
    if (bouncy) bounce(1'b1);
    else button = 1'b1;
    repeat (hold) @(negedge clk);
    if (bouncy) bounce(1'b0);
    else button = 1'b0;
    repeat (50) @(negedge clk);
    ptr_m = (ptr_m + 1) % 16;
  endtask

  // two frames checked against an ideal timeline from an3 fall
  task automatic frame_check(input int p0);
    logic prev;
    bit   found;
    found = 0;
    @(negedge clk);
    prev = an3;
    for (int k = 0; k < 8 * DC + 4; k++) begin
      @(negedge clk);
      if (prev && !an3) begin
        found = 1;
        break;
      end
      prev = an3;
    end
    if (!found) begin
      check("an3_fall_timeout", 0, 1);
      return;
    end
    for (int p = 0; p < 8 * DC; p++) begin
      int       dg;
      bit       low;
      logic [3:0] exp_an;
      logic     exp_dp;
      if (p > 0) @(negedge clk);
      dg = (p / DC) % 4;
      low = (p % DC) < (DC - 2);
      exp_an = low ? ~(4'b1000 >> dg) : 4'hF;
      check("anodes", {an3, an2, an1, an0}, exp_an);
      if (low)
        check("seg", {a, b, c, d, e, f, g},
              glyph(p0 + dg));
      exp_dp = 1'b1;
`ifdef FOUR_DIGIT_LED_DP_MARK_EN
      if (low && ((p0 + dg) % 16 == 0))
        exp_dp = 1'b0;
`endif
      check("dp", dp, exp_dp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int k;
    repeat (3) @(negedge clk);
    check("rst_an", {an3, an2, an1, an0}, 4'hF);
    check("rst_seg", {a, b, c, d, e, f, g}, 7'h7F);
    check("rst_dp", dp, 1'b1);
    reset = 1'b1;
    frame_check(0);

    // async reset mid-scan after a press
    press(0, 40);
    repeat ($urandom_range(20, 60)) @(negedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("async_an", {an3, an2, an1, an0}, 4'hF);
    check("async_seg", {a, b, c, d, e, f, g}, 7'h7F);
    check("async_dp", dp, 1'b1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ptr_m = 0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (an3 && k < 10);
    check("an3_first_low", k, 3);
    frame_check(0);

    // bouncy press
    press(1, 50);
    frame_check(ptr_m);
    check("bouncy_ptr", ptr_m, 1);

    // two clean presses and a long hold
    do_reset();
    press(0, 50);
    press(0, 50);
    frame_check(ptr_m);
    press(0, 500);
    frame_check(ptr_m);

    // short glitches on press and release
    @(negedge clk);
    button = 1'b1;
    repeat (DEB - 2) @(negedge clk);
    button = 1'b0;
    repeat (40) @(negedge clk);
    frame_check(ptr_m);
    button = 1'b1;
    repeat (40) @(negedge clk);
    button = 1'b0;
    repeat (DEB - 2) @(negedge clk);
    button = 1'b1;
    repeat (40) @(negedge clk);
    button = 1'b0;
    repeat (50) @(negedge clk);
    ptr_m = (ptr_m + 1) % 16;
    frame_check(ptr_m);

    // wrap: 13 presses then one more
    do_reset();
    for (int i = 0; i < 13; i++)
      press($urandom_range(0, 1), 30);
    frame_check(ptr_m);
    press(0, 30);
    frame_check(ptr_m);

    // randomized press bursts
    for (int it = 0; it < 5; it++) begin
      int n;
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++)
        press($urandom_range(0, 1),
              $urandom_range(30, 80));
      frame_check(ptr_m);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
